sram_simulation: RTL and testbench
==================================

SRAM_SIMULATION -- requirements
Module: sram_simulation

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, word width; ADDR_W, default 26, address width; ROW_BASE, default 0, row-cache base address; OUT_BASE, default 9000, output-array base address; DEPTH, default 1024, words per region.
REQ-002 Port list (name, direction, width, meaning), clock and reset first:
- clk  input  1  single clock; all state SHALL update on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sdram_data  input  32  write data for the row-cache region.
- wb_data  input  32  write data for the output-array region.
- address  input  26  absolute word address.
- mode  input  1  operation select: 1 = read, 0 = write.
- addrCalcMode  input  1  region select: 1 = row cache, 0 = output array.
- enable  input  1  request strobe, sampled at the rising edge of clk.
- out_data  output  32  registered read data.
- dataReadValid  output  1  registered one-cycle read-valid pulse.
REQ-003 The design SHALL have exactly one clock (clk) and one asynchronous active-high reset (rst).

Function
REQ-004 Two independent storage regions SHALL exist, each DEPTH x DATA_W:
- rowCache at ROW_BASE
- outputArr at OUT_BASE
REQ-005 Region index SHALL be address minus the selected base: ROW_BASE if addrCalcMode=1, else OUT_BASE. Compute the subtraction at ADDR_W width.
REQ-006 An address is in range when ROW_BASE <= address < ROW_BASE+DEPTH (row cache) or OUT_BASE <= address < OUT_BASE+DEPTH (output array), for the selected region only.
REQ-007 Write: on a rising edge with enable=1 and mode=0, an in-range address SHALL store the data of the selected region, taking effect that edge:
- sdram_data when addrCalcMode=1
- wb_data when addrCalcMode=0
REQ-008 A write SHALL leave out_data unchanged and SHALL force dataReadValid to 0.
REQ-009 Read: on a rising edge with enable=1 and mode=1, out_data SHALL register the selected region's word and dataReadValid SHALL be 1 for that cycle. Latency is 1 cycle: the data is visible after the edge that samples enable.
REQ-010 On any edge with enable=0, dataReadValid SHALL return to 0 and out_data SHALL hold its value.
REQ-011 If enable is held high across consecutive read edges, each edge SHALL perform a read and dataReadValid SHALL stay 1.
REQ-012 An out-of-range read SHALL return 0 and still pulse dataReadValid. An out-of-range write SHALL be ignored.
REQ-013 A read of a word written on an earlier edge SHALL return the new value. There is no same-edge read-after-write, since one operation occurs per edge.
REQ-014 The two regions SHALL never alias: writing one region SHALL not modify the other.

Reset
REQ-015 While rst=1, regardless of clk:
- out_data = 0
- dataReadValid = 0
- all words of both regions = 0
REQ-016 Reset asserted mid-operation SHALL abort that operation; the first request after rst deasserts SHALL be serviced normally.

Structure
REQ-017 A shared package SHALL hold:
- DATA_W, ADDR_W, ROW_BASE, OUT_BASE and DEPTH defaults
- the mode encodings (READ=1, WRITE=0)
- the region encodings (ROW_CACHE=1, OUT_ARR=0)
REQ-018 One sub-module, sram_bank, SHALL be instantiated twice, once per region. It is a DEPTH-word synchronous-write, registered-read array with rst clear, in-range check and local index.
REQ-019 The top level SHALL contain only region select, write-data select and output muxing/registering.

Verification
REQ-020 Row-cache write/read: write 99 to address 0 and 100 to address 1 via sdram_data (addrCalcMode=1). Read each with a one-cycle enable pulse -> out_data 99 and 100 respectively, dataReadValid=1 for exactly one cycle, then 0.
REQ-021 Output-array write/read: write 99 to address 9000 and 100 to address 9001 via wb_data (addrCalcMode=0) -> reads return 99 and 100 with one-cycle valid pulses.
REQ-022 Isolation:
- write 55 to 9000 with addrCalcMode=0 -> row-cache address 0 still reads 99
- write with enable=0 -> no change
REQ-023 Out of range:
- read address 5000 with addrCalcMode=1 -> out_data 0, dataReadValid 1
- write to 10024 with addrCalcMode=0 -> ignored
REQ-024 Reset: assert rst mid-read -> dataReadValid and out_data go 0 immediately; after release, read of address 1 -> 0.
REQ-025 Back-to-back: enable held high for 3 read cycles on addresses 0, 1, 0 -> out_data 99, 100, 99 on consecutive cycles with dataReadValid continuously 1.

Source files
------------

// File: rtl/sram_simulation_pkg.sv
// Shared defaults and encodings for the two-region SRAM model.
package sram_simulation_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 26;
    localparam int unsigned DEF_ROW_BASE = 0;
    localparam int unsigned DEF_OUT_BASE = 9000;
    localparam int unsigned DEF_DEPTH    = 1024;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } mode_e;

    typedef enum logic {
        OUT_ARR   = 1'b0,
        ROW_CACHE = 1'b1
    } region_e;

endpackage

// File: rtl/sram_simulation_bank.sv
// One DEPTH-word region: synchronous write, registered read, async clear.
module sram_bank #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 26,
    parameter int unsigned BASE   = 0,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  idx;
    logic              in_range;

    // Modular subtraction: addresses below BASE wrap high and fail the bound.
    assign offset   = address - ADDR_W'(BASE);
    assign in_range = offset < ADDR_W'(DEPTH);
    assign idx      = offset[IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem     <= '{default: '0};
            rd_data <= '0;
        end else begin
            if (wr_en && in_range)
                mem[idx] <= wr_data;
            if (rd_en)
                rd_data <= in_range ? mem[idx] : '0;
        end
    end

endmodule

// File: rtl/sram_simulation.sv
// Top level: region/data select around two sram_bank instances, read-valid register.
module sram_simulation
    import sram_simulation_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ROW_BASE = DEF_ROW_BASE,
    parameter int unsigned OUT_BASE = DEF_OUT_BASE,
    parameter int unsigned DEPTH    = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sdram_data,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] address,
    input  logic              mode,
    input  logic              addrCalcMode,
    input  logic              enable,
    output logic [DATA_W-1:0] out_data,
    output logic              dataReadValid
);

    region_e           region;
    region_e           rd_region;
    mode_e             op;
    logic              do_read;
    logic              do_write;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] row_rd;
    logic [DATA_W-1:0] out_rd;

    assign region   = region_e'(addrCalcMode);
    assign op       = mode_e'(mode);
    assign do_read  = enable && (op == READ);
    assign do_write = enable && (op == WRITE);
    assign wr_data  = (region == ROW_CACHE) ? sdram_data : wb_data;

    sram_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BASE   (ROW_BASE),
        .DEPTH  (DEPTH)
    ) u_row_cache (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .wr_en   (do_write && (region == ROW_CACHE)),
        .rd_en   (do_read  && (region == ROW_CACHE)),
        .wr_data (wr_data),
        .rd_data (row_rd)
    );

    sram_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BASE   (OUT_BASE),
        .DEPTH  (DEPTH)
    ) u_output_arr (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .wr_en   (do_write && (region == OUT_ARR)),
        .rd_en   (do_read  && (region == OUT_ARR)),
        .wr_data (wr_data),
        .rd_data (out_rd)
    );

    // Each bank holds its last read word; the latched region picks which one is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataReadValid <= 1'b0;
            rd_region     <= OUT_ARR;
        end else begin
            dataReadValid <= do_read;
            if (do_read)
                rd_region <= region;
        end
    end

    assign out_data = (rd_region == ROW_CACHE) ? row_rd : out_rd;

endmodule

// File: tb/tb_sram_simulation.sv
// Randomised and directed checks of sram_simulation against an array-based reference model.
module tb_sram_simulation;

    localparam int unsigned ROW_BASE = 0;
    localparam int unsigned OUT_BASE = 9000;
    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned AMASK    = 32'h03FF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sdram_data = '0;
    logic [31:0] wb_data    = '0;
    logic [25:0] address    = '0;
    logic        mode = 1'b0;
    logic        addrCalcMode = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] out_data;
    logic        dataReadValid;

    int tests = 0;
    int fails = 0;

    logic [31:0] row_m [DEPTH];
    logic [31:0] out_m [DEPTH];
    logic [31:0] exp_data;
    logic        exp_valid;

    sram_simulation dut (
        .clk           (clk),
        .rst           (rst),
        .sdram_data    (sdram_data),
        .wb_data       (wb_data),
        .address       (address),
        .mode          (mode),
        .addrCalcMode  (addrCalcMode),
        .enable        (enable),
        .out_data      (out_data),
        .dataReadValid (dataReadValid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, want, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            row_m[i] = '0;
            out_m[i] = '0;
        end
        exp_data  = '0;
        exp_valid = 1'b0;
    endtask

    // Drive one request at the falling edge, let the rising edge sample it, then compare.
    task automatic op(input string tag, input logic en, input logic rd, input logic row,
                      input int unsigned addr, input logic [31:0] data);
        int unsigned base;
        bit          hit;
        @(negedge clk);
        enable       = en;
        mode         = rd;
        addrCalcMode = row;
        address      = addr[25:0];
        sdram_data   = row ? data : $urandom;
        wb_data      = row ? $urandom : data;
        @(posedge clk);
        #1;
        base = row ? ROW_BASE : OUT_BASE;
        hit  = (addr >= base) && (addr < base + DEPTH);
        if (!en) begin
            exp_valid = 1'b0;
        end else if (rd) begin
            exp_valid = 1'b1;
            exp_data  = !hit ? 32'd0 : (row ? row_m[addr - base] : out_m[addr - base]);
        end else begin
            exp_valid = 1'b0;
            if (hit) begin
                if (row) row_m[addr - base] = data;
                else     out_m[addr - base] = data;
            end
        end
        check_eq({tag, ".data"}, out_data, exp_data);
        check_eq({tag, ".valid"}, {31'd0, dataReadValid}, {31'd0, exp_valid});
    endtask

    task automatic idle(input string tag);
        op(tag, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    function automatic int unsigned pick_addr(input logic row);
        int unsigned base = row ? ROW_BASE : OUT_BASE;
        int unsigned r    = $urandom_range(0, 9);
        if (r < 7)       return base + $urandom_range(0, 15);
        else if (r == 7) return base + DEPTH - 1 + $urandom_range(0, 1);
        else if (r == 8) return (base + DEPTH + $urandom_range(0, 20)) & AMASK;
        else             return $urandom & AMASK;
    endfunction

    initial begin
        model_reset();
        #12;
        check_eq("reset.data", out_data, 32'd0);
        check_eq("reset.valid", {31'd0, dataReadValid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Row cache write/read with single-cycle pulses
        op("row_wr0", 1, 0, 1, 0, 99);
        op("row_wr1", 1, 0, 1, 1, 100);
        op("row_rd0", 1, 1, 1, 0, 0);
        idle("row_rd0_drop");
        op("row_rd1", 1, 1, 1, 1, 0);
        idle("row_rd1_drop");

        // Output array write/read
        op("out_wr0", 1, 0, 0, 9000, 99);
        op("out_wr1", 1, 0, 0, 9001, 100);
        op("out_rd0", 1, 1, 0, 9000, 0);
        idle("out_rd0_drop");
        op("out_rd1", 1, 1, 0, 9001, 0);
        op("wr_clears_valid", 1, 0, 0, 9002, 7);

        // Isolation and disabled writes
        op("iso_wr", 1, 0, 0, 9000, 55);
        op("iso_rd_row0", 1, 1, 1, 0, 0);
        op("iso_rd_out0", 1, 1, 0, 9000, 0);
        op("dis_wr", 0, 0, 1, 1, 12345);
        op("dis_rd_row1", 1, 1, 1, 1, 0);

        // Out of range in both directions
        op("oor_rd_row", 1, 1, 1, 5000, 0);
        op("oor_wr_out", 1, 0, 0, 10024, 777);
        op("oor_rd_out", 1, 1, 0, 10024, 0);
        op("edge_wr_out", 1, 0, 0, 10023, 4242);
        op("edge_rd_out", 1, 1, 0, 10023, 0);
        op("below_rd_out", 1, 1, 0, 8999, 0);

        // Back-to-back reads with enable held
        op("b2b_0", 1, 1, 1, 0, 0);
        op("b2b_1", 1, 1, 1, 1, 0);
        op("b2b_2", 1, 1, 1, 0, 0);
        idle("b2b_drop");

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            logic        row = 1'($urandom);
            logic        en  = ($urandom_range(0, 7) != 0);
            logic        rd  = 1'($urandom);
            op("rand", en, rd, row, pick_addr(row), $urandom);
        end

        // Asynchronous reset during a read
        op("pre_rst_rd", 1, 1, 1, 1, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_async.data", out_data, 32'd0);
        check_eq("rst_async.valid", {31'd0, dataReadValid}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_hold.valid", {31'd0, dataReadValid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op("post_rst_rd1", 1, 1, 1, 1, 0);
        op("post_rst_rd_out", 1, 1, 0, 9000, 0);
        op("post_rst_wr", 1, 0, 1, 3, 31337);
        op("post_rst_rd3", 1, 1, 1, 3, 0);
        idle("final_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
